pattern_serializer: RTL and testbench

Serial pattern transmitter and stimulus source for the serial sequence detectors in this design.
- Accepts a parallel pattern, an effective bit length and a repeat count through a valid/ready handshake.
- Shifts the pattern out MSB-first on a single-bit line, one bit per clock.
- Optional idle gaps between repetitions; a one-cycle done pulse at the end.
- Drives the 1-bit `in` of a detector under test directly.

---
 rtl/pattern_serializer.sv | 167 ++++++++++++++++
 tb/tb_pattern_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_serializer.sv
// Serial pattern source: latches a parallel pattern and shifts it out MSB-first, L bits x R repetitions.
// Latency: first bit on out one cycle after the accept edge; done pulses one cycle after the last bit.
// Backpressure: start_ready is high only in IDLE; start_valid while busy is dropped, not queued.
module pattern_serializer #(
    parameter int   WIDTH    = 8,
    parameter int   LEN_W    = 4,
    parameter int   REP_W    = 4,
    parameter int   GAP      = 1,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             out,
    output logic             out_en,
    output logic             done
);

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam int               GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAPW, DONE} state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   pat_q,    pat_d;     // latched pattern, left-aligned so bit L-1 sits at the MSB
    logic [WIDTH-1:0]   shift_q,  shift_d;   // working copy, reloaded from pat_q every repetition
    logic [LEN_W-1:0]   len_q,    len_d;
    logic [LEN_W-1:0]   bitcnt_q, bitcnt_d;  // bits still to emit in the current repetition
    logic [REP_W-1:0]   repcnt_q, repcnt_d;  // repetitions remaining, including the current one
    logic [GAP_W-1:0]   gapcnt_q, gapcnt_d;
    logic               out_q,    out_d;
    logic               out_en_q, out_en_d;
    logic               done_q,   done_d;

    logic [LEN_W-1:0]   eff_len;
    logic [REP_W-1:0]   eff_reps;
    logic [WIDTH-1:0]   aligned;

    assign start_ready = (state_q == IDLE);
    assign out         = out_q;
    assign out_en      = out_en_q;
    assign done        = done_q;

    // Clamp request fields and left-align the pattern so the shifter always emits its MSB.
    always_comb begin
        eff_len  = ((pat_len == '0) || (pat_len > WIDTH_L)) ? WIDTH_L : pat_len;
        eff_reps = (reps == '0) ? REP_W'(1) : reps;
        aligned  = pattern << (WIDTH_L - eff_len);
    end

    // Next-state and next-output logic; outputs are computed here and registered below.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        shift_d  = shift_q;
        len_d    = len_q;
        bitcnt_d = bitcnt_q;
        repcnt_d = repcnt_q;
        gapcnt_d = gapcnt_q;
        out_d    = out_q;
        out_en_d = out_en_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_valid && !abort) begin
                    state_d  = SEND;
                    pat_d    = aligned;
                    shift_d  = aligned;
                    len_d    = eff_len;
                    bitcnt_d = eff_len;
                    repcnt_d = eff_reps;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d  = IDLE;
                    out_d    = IDLE_LVL;
                    out_en_d = 1'b0;
                end else if (bitcnt_q != '0) begin
                    out_d    = shift_q[WIDTH-1];
                    out_en_d = 1'b1;
                    shift_d  = shift_q << 1;
                    bitcnt_d = bitcnt_q - LEN_W'(1);
                end else if (repcnt_q != REP_W'(1)) begin
                    repcnt_d = repcnt_q - REP_W'(1);
                    if (GAP > 0) begin
                        state_d  = GAPW;
                        out_d    = IDLE_LVL;
                        out_en_d = 1'b0;
                        gapcnt_d = GAP_W'(GAP - 1);
                    end else begin
                        // No gap: the first bit of the next repetition goes out on this edge.
                        out_d    = pat_q[WIDTH-1];
                        out_en_d = 1'b1;
                        shift_d  = pat_q << 1;
                        bitcnt_d = len_q - LEN_W'(1);
                    end
                end else begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    out_d    = IDLE_LVL;
                    out_en_d = 1'b0;
                end
            end
            GAPW: begin
                if (abort) begin
                    state_d  = IDLE;
                    out_d    = IDLE_LVL;
                    out_en_d = 1'b0;
                end else if (gapcnt_q != '0) begin
                    gapcnt_d = gapcnt_q - GAP_W'(1);
                end else begin
                    // Last gap cycle ends by emitting the first bit of the next repetition.
                    state_d  = SEND;
                    out_d    = pat_q[WIDTH-1];
                    out_en_d = 1'b1;
                    shift_d  = pat_q << 1;
                    bitcnt_d = len_q - LEN_W'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                out_d    = IDLE_LVL;
                out_en_d = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                out_d    = IDLE_LVL;
                out_en_d = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; async reset returns everything to idle immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            shift_q  <= '0;
            len_q    <= '0;
            bitcnt_q <= '0;
            repcnt_q <= '0;
            gapcnt_q <= '0;
            out_q    <= IDLE_LVL;
            out_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            shift_q  <= shift_d;
            len_q    <= len_d;
            bitcnt_q <= bitcnt_d;
            repcnt_q <= repcnt_d;
            gapcnt_q <= gapcnt_d;
            out_q    <= out_d;
            out_en_q <= out_en_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: one instance with a one-cycle gap, one with no gap.
// Each cycle is observed as {start_ready, out, out_en, done} and compared to a stream model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pattern_serializer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sv0 = 1'b0, sv1 = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] pat_len = '0;
    logic [3:0] reps = '0;
    logic       abort = 1'b0;
    logic       rdy0, out0, en0, done0;
    logic       rdy1, out1, en1, done1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    always #5 clk = ~clk;

    pattern_serializer #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP(1), .IDLE_LVL(1'b0)) dut1 (
        .clk(clk), .rstn(rstn), .start_valid(sv1), .start_ready(rdy1),
        .pattern(pattern), .pat_len(pat_len), .reps(reps), .abort(abort),
        .out(out1), .out_en(en1), .done(done1));

    pattern_serializer #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP(0), .IDLE_LVL(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .start_valid(sv0), .start_ready(rdy0),
        .pattern(pattern), .pat_len(pat_len), .reps(reps), .abort(abort),
        .out(out0), .out_en(en0), .done(done0));

    function automatic logic [3:0] sample(input bit g);
        return g ? {rdy1, out1, en1, done1} : {rdy0, out0, en0, done0};
    endfunction

    // Reference stream, appended to exp_q: accept cycle, L*R bits with gaps between repetitions,
    // the done cycle, then the first idle cycle with start_ready back high.
    function automatic void build_exp(input logic [7:0] pat, input logic [3:0] len,
                                      input logic [3:0] rp, input int gap);
        int L;
        int R;
        L = (len == 0 || len > 8) ? 8 : int'(len);
        R = (rp == 0) ? 1 : int'(rp);
        exp_q.push_back(4'b0000);
        for (int r = 0; r < R; r++) begin
            for (int i = 0; i < L; i++) exp_q.push_back({1'b0, pat[L-1-i], 1'b1, 1'b0});
            if (r < R - 1)
                for (int k = 0; k < gap; k++) exp_q.push_back(4'b0000);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b1000);
    endfunction

    // Drives one request and records n cycles starting at the accept cycle.
    // start_valid stays high through sample index hold; with hold 0 the request
    // inputs are scrambled after accept, which must not disturb the transfer.
    task automatic capture(input bit g, input logic [7:0] pat, input logic [3:0] len,
                           input logic [3:0] rp, input int n, input int hold);
        obs_q.delete();
        @(negedge clk);
        pattern = pat; pat_len = len; reps = rp;
        if (g) sv1 = 1'b1; else sv0 = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_q.push_back(sample(g));
            if (i >= hold) begin sv1 = 1'b0; sv0 = 1'b0; end
            if (hold == 0) begin
                pattern = 8'($urandom);
                pat_len = 4'($urandom_range(15, 0));
                reps    = 4'($urandom_range(15, 0));
            end
        end
        sv1 = 1'b0; sv0 = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({sample(1), sample(0)} !== 8'b1000_1000)
            $display("FAIL reset_hold: got %b, required 10001000", {sample(1), sample(0)});
        else n_pass++;
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sample(1), sample(0)} !== 8'b1000_1000)
            $display("FAIL reset_release: got %b, required 10001000", {sample(1), sample(0)});
        else n_pass++;
    endtask

    task automatic test_single;
        exp_q.delete();
        build_exp(8'b0000_0110, 4'd4, 4'd1, 1);
        capture(1'b1, 8'b0000_0110, 4'd4, 4'd1, exp_q.size(), 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL single[%0d]: rdy/out/en/done %b, required %b", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_gap_reps;
        exp_q.delete();
        build_exp(8'b0000_0110, 4'd4, 4'd3, 1);
        capture(1'b1, 8'b0000_0110, 4'd4, 4'd3, exp_q.size(), 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL gap_reps[%0d]: rdy/out/en/done %b, required %b", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_nogap_clamp;
        int ones;
        exp_q.delete();
        build_exp(8'hA5, 4'd0, 4'd2, 0);
        capture(1'b0, 8'hA5, 4'd0, 4'd2, exp_q.size(), 0);
        ones = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            ones += int'(obs_q[i][1]);
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL nogap_clamp[%0d]: rdy/out/en/done %b, required %b", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (ones !== 16) $display("FAIL nogap_en_count: got %0d, required 16", ones);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int n1;
        exp_q.delete();
        build_exp(8'b0000_0110, 4'd4, 4'd1, 1);
        n1 = exp_q.size();
        build_exp(8'b0000_0110, 4'd4, 4'd1, 1);
        capture(1'b1, 8'b0000_0110, 4'd4, 4'd1, exp_q.size(), n1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL busy[%0d]: rdy/out/en/done %b, required %b", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (sample(1) !== 4'b1000) $display("FAIL busy_no_third: got %b, required 1000", sample(1));
        else n_pass++;
    endtask

    task automatic test_abort;
        int seen;
        @(negedge clk);
        pattern = 8'b0000_0110; pat_len = 4'd4; reps = 4'd2; sv1 = 1'b1;
        @(negedge clk) sv1 = 1'b0;                   // accept cycle
        @(negedge clk);                              // first bit
        @(negedge clk);                              // second bit: raise abort
        n_checks++;
        if (sample(1) !== 4'b0110) $display("FAIL abort_pre: got %b, required 0110", sample(1));
        else n_pass++;
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        n_checks++;
        if (sample(1) !== 4'b1000) $display("FAIL abort_next: got %b, required 1000", sample(1));
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done1 || en1 || !rdy1) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL abort_quiet: active cycles %0d, required 0", seen);
        else n_pass++;
        // abort in IDLE must block a simultaneous request
        sv1 = 1'b1; abort = 1'b1;
        @(negedge clk) begin sv1 = 1'b0; abort = 1'b0; end
        n_checks++;
        if (sample(1) !== 4'b1000) $display("FAIL abort_blocks_accept: got %b, required 1000", sample(1));
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        // reset while out = 1 during SEND
        @(negedge clk);
        pattern = 8'b0000_0110; pat_len = 4'd4; reps = 4'd2; sv1 = 1'b1;
        @(negedge clk) sv1 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (sample(1) !== 4'b1000) $display("FAIL reset_in_send: got %b, required 1000", sample(1));
        else n_pass++;
        @(negedge clk) rstn = 1'b1;
        // reset during GAPW, then a clean transfer must follow
        sv1 = 1'b1;
        @(negedge clk) sv1 = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (sample(1) !== 4'b0000) $display("FAIL gap_cycle: got %b, required 0000", sample(1));
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (sample(1) !== 4'b1000) $display("FAIL reset_in_gap: got %b, required 1000", sample(1));
        else n_pass++;
        @(negedge clk) rstn = 1'b1;
        exp_q.delete();
        build_exp(8'b1101_0011, 4'd7, 4'd2, 1);
        capture(1'b1, 8'b1101_0011, 4'd7, 4'd2, exp_q.size(), 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL after_reset[%0d]: rdy/out/en/done %b, required %b", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        // reset while done is high
        @(negedge clk);
        pattern = 8'b0000_0110; pat_len = 4'd4; reps = 4'd1; sv1 = 1'b1;
        @(negedge clk) sv1 = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (sample(1) !== 4'b0001) $display("FAIL done_cycle: got %b, required 0001", sample(1));
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (sample(1) !== 4'b1000) $display("FAIL reset_in_done: got %b, required 1000", sample(1));
        else n_pass++;
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic test_random;
        bit         g;
        logic [7:0] pat;
        logic [3:0] len;
        logic [3:0] rp;
        for (int t = 0; t < 24; t++) begin
            g   = 1'($urandom_range(1, 0));
            pat = 8'($urandom);
            len = 4'($urandom_range(15, 0));
            rp  = 4'($urandom_range(4, 0));
            exp_q.delete();
            build_exp(pat, len, rp, g ? 1 : 0);
            capture(g, pat, len, rp, exp_q.size(), 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i])
                    $display("FAIL random%0d[%0d] g=%0d pat=%h len=%0d reps=%0d: %b, required %b",
                             t, i, g, pat, len, rp, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_gap_reps;
        test_nogap_clamp;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
